// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two write ports (wr1 wins on collision),
// optional write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_busy,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_busy
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_busy;

  logic [NREG-1:0]   w_wr0_hit;
  logic [NREG-1:0]   w_wr1_hit;
  logic [NREG-1:0]   w_rsv_hit;

  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic              w_rd_busy [2];

  // Per-register decode of the two write ports and the reserve port; register 0 is
  // masked out here so the hardwired zero never gets written or reserved.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    w_wr0_hit = '0;
    w_wr1_hit = '0;
    w_rsv_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      if (!(ZERO_REG && i == 0)) begin
        w_wr0_hit[i] = wr0_en && (wr0_addr == ADDR_W'(i));
        w_wr1_hit[i] = wr1_en && (wr1_addr == ADDR_W'(i));
        w_rsv_hit[i] = rsv_en && (rsv_addr == ADDR_W'(i));
      end
    end
  end

  // NOTE: the array is reset because reads must return zero right after reset; this
  // rules out mapping it onto a RAM macro, which is acceptable at this depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int i = 0; i < NREG; i++) begin
        if (w_wr1_hit[i]) begin
          r_mem[i] <= wr1_data;
        end else if (w_wr0_hit[i]) begin
          r_mem[i] <= wr0_data;
        end
      end
    end
  end

  // A reserve on the same edge as a write belongs to the newer producer, so set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_rsv_hit[i]) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr0_hit[i] || w_wr1_hit[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign w_rd_addr[0] = rd1_addr;
  assign w_rd_addr[1] = rd2_addr;

  // Read path: stored state, then bypass (wr1 applied last so it wins), then zero register,
  // then reset gating so the outputs are quiet while rst is low.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_data[p] = r_mem[w_rd_addr[p]];
      w_rd_busy[p] = r_busy[w_rd_addr[p]];
      if (BYPASS) begin
        if (wr0_en && (wr0_addr == w_rd_addr[p])) begin
          w_rd_data[p] = wr0_data;
          w_rd_busy[p] = rsv_en && (rsv_addr == w_rd_addr[p]);
        end
        if (wr1_en && (wr1_addr == w_rd_addr[p])) begin
          w_rd_data[p] = wr1_data;
          w_rd_busy[p] = rsv_en && (rsv_addr == w_rd_addr[p]);
        end
      end
      if (ZERO_REG && (w_rd_addr[p] == '0)) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end
      if (!rst) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd1_data = w_rd_data[0];
  assign rd1_busy = w_rd_busy[0];
  assign rd2_data = w_rd_data[1];
  assign rd2_busy = w_rd_busy[1];

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the processor datapath; next generation of the 8×16 two-read/one-write file. Adds configurable width and depth, a second write port with fixed priority, optional write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard. Decode uses the scoreboard for hazard stalls; writeback and the load unit drive the two write ports.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; depth NREG = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: reads return same-cycle write data on address match
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr0_en  in  1  write port 0 enable (ALU writeback)
- wr0_addr  in  ADDR_W  write port 0 destination
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (load unit)
- wr1_addr  in  ADDR_W  write port 1 destination
- wr1_data  in  DATA_W  write port 1 data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- rd1_addr  in  ADDR_W  read port 1 address
- rd1_data  out  DATA_W  read port 1 data
- rd1_busy  out  1  busy bit of rd1_addr
- rd2_addr  in  ADDR_W  read port 2 address
- rd2_data  out  DATA_W  read port 2 data
- rd2_busy  out  1  busy bit of rd2_addr

## Operation
- Storage: NREG × DATA_W array plus NREG-bit busy vector, both cleared by rst.
- Write: on rising clk, each enabled port writes its data to its address.
- Both ports same address same edge: wr1 data stored; wr0 dropped.
- Busy clear: any enabled write to address A clears busy[A] on that edge.
- Busy set: rsv_en sets busy[rsv_addr] on rising clk.
- Reserve and write to same address same edge: busy ends 1 (new producer wins); data still written.
- Reserve of an already-busy register: busy stays 1; no error, no counting.
- Read: combinational. rdN_data = array[rdN_addr]; rdN_busy = busy[rdN_addr].
- BYPASS=1: if wrX_en and wrX_addr == rdN_addr, rdN_data = wrX_data (wr1 over wr0) and rdN_busy = 0 unless rsv_en to the same address in that cycle, then 1. BYPASS=0: rdN_data/busy reflect stored state only.
- ZERO_REG=1: writes and reserves to address 0 ignored; rdN_data = 0 and rdN_busy = 0 for address 0 regardless of bypass.
- Widths exact: no truncation or extension; ADDR_W covers whole array, no out-of-range addresses.

## Timing
- Reset: rst low clears all registers and busy bits immediately, independent of clk; rd1_data = rd2_data = 0, rd1_busy = rd2_busy = 0 while rst low. Writes and reserves ignored while rst low.
- rst deassertion is synchronised externally; first write takes effect on the first rising edge with rst high.
- Write latency: data visible on reads the cycle after the edge (0 cycles with BYPASS=1).
- Busy latency: set/clear visible from the edge onward; bypass gives same-cycle clear visibility.
- Reset mid-operation: pending writes/reserves on the edge coinciding with rst low are lost.

## Test plan
- Reset: write 0xBEEF to r3, assert rst low mid-cycle -> rd1_data(r3) = 0x0000 immediately, all busy = 0.
- Write/read: wr0 r5 = 0x1234, next cycle rd1=r5, rd2=r5 -> both 0x1234; BYPASS=1 -> 0x1234 in the write cycle itself.
- Port collision: wr0 r2 = 0x1111 and wr1 r2 = 0x2222 same edge -> r2 reads 0x2222 afterwards; bypass during that cycle also 0x2222.
- Scoreboard: rsv r4 -> rd1_busy = 1 next cycle; wr1 r4 = 0x00AA -> busy 0, data 0x00AA; reserve+write r4 same edge -> busy 1, data updated.
- Zero register (ZERO_REG=1): wr0 r0 = 0xFFFF, rsv r0 -> rd1_data = 0, rd1_busy = 0; ZERO_REG=0 -> reads 0xFFFF, busy 1.
- Parameters: DATA_W=32, ADDR_W=5 -> write 0xDEADBEEF to r31, read back exact; BYPASS=0 -> old value on read in write cycle.
